// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC scan sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int FRAME_BITS = 16;  // SCLK periods per serial frame
  localparam int ADDR_FIRST = 2;   // first period carrying the channel address
  localparam int DATA_FIRST = 4;   // first period carrying conversion data
  localparam int ADC_W      = 12;  // native ADC word width

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK period/half counter: SCLK level, rise/fall strobes and period index.
// Latency: counter restarts at 0 on the cycle after restart_i; strobes are combinational.
// Backpressure: none; free-runs while run_i is high.
module adc_sclk_gen import adc_seq_pkg::*; #(
  parameter int SCLK_DIV = 25
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       run_i,
  input  logic       restart_i,
  output logic       sclk_hi_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic [3:0] period_o
);

  localparam int CW = $clog2(2 * SCLK_DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(SCLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * SCLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    per_q, per_d;

  // Next count: wrap at the end of each period and advance the period index.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    per_d = per_q;
    if (!run_i || restart_i) begin
      cnt_d = '0;
      per_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      per_d = per_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

  // First half of a period is low, second half high; rise marks the first high
  // cycle, fall marks the last cycle before SCLK drops at the next period.
  assign sclk_hi_o = (cnt_q >= CNT_HALF);
  assign rise_o    = (cnt_q == CNT_HALF);
  assign fall_o    = (cnt_q == CNT_LAST);
  assign period_o  = per_q;

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans a channel mask over a pipelined serial ADC, returning one result per channel.
// Latency: result valid one cycle after the last SCLK rise of each non-priming frame.
// Backpressure: single result register; an unconsumed result is overwritten and flags overrun.
module adc_scan_sequencer import adc_seq_pkg::*; #(
  parameter int NUM_CH   = 8,
  parameter int SCLK_DIV = 25,
  parameter int RES_W    = 10
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cmd_start,
  input  logic [NUM_CH-1:0] cmd_chan_mask,
  input  logic              cmd_continuous,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic              adc_din,
  input  logic              adc_dout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2:0]        res_chan,
  output logic [RES_W-1:0]  res_data,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam logic [3:0] PER_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0] ADDR_P   = 4'(ADDR_FIRST);
  localparam logic [3:0] DATA_P   = 4'(DATA_FIRST);

  seq_state_e state_q, state_d;
  logic [7:0] mask_in, mask_q, rem_q, rem_d, src;
  logic [2:0] addr_q, addr_d, prev_q, prev_d;
  logic       prime_q, prime_d, last_q, last_d, cont_q;
  logic [ADC_W-2:0] shift_q;
  logic [ADC_W-1:0] word;
  logic       res_valid_q, overrun_q;
  logic [2:0] res_chan_q;
  logic [RES_W-1:0] res_data_q;
  logic       sg_hi, sg_rise, sg_fall, run, restart, setup, start_idle, load;
  logic [3:0] sg_per;

  adc_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .run_i         (run),
    .restart_i     (restart),
    .sclk_hi_o     (sg_hi),
    .rise_o        (sg_rise),
    .fall_o        (sg_fall),
    .period_o      (sg_per)
  );

  // Zero-extend the command mask to the full 3-bit channel space.
  always_comb begin
    mask_in = '0;
    mask_in[NUM_CH-1:0] = cmd_chan_mask;
  end

  assign start_idle = (state_q == IDLE) && cmd_start;
  assign run        = (state_q == FRAME) || (state_q == GAP);
  assign restart    = (state_d != state_q);
  assign word       = {shift_q, adc_dout};
  assign load       = (state_q == FRAME) && sg_rise && (sg_per == PER_LAST) && !prime_q;

  // Next-state logic for the scan FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_start) state_d = (mask_in == 8'd0) ? DONE : FRAME;
      FRAME:   if (sg_fall && (sg_per == PER_LAST)) state_d = GAP;
      GAP:     if (sg_fall) state_d = last_q ? DONE : FRAME;
      DONE:    state_d = (cont_q && (mask_q != 8'd0)) ? FRAME : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame setup: pick the next channel to address; once the mask is used up the
  // final frame re-addresses the last channel just to retrieve its conversion.
  always_comb begin
    src     = mask_q;
    if (state_q == IDLE)     src = mask_in;
    else if (state_q == GAP) src = rem_q;
    setup   = (state_d == FRAME) && (state_q != FRAME);
    addr_d  = addr_q;
    rem_d   = rem_q;
    prev_d  = prev_q;
    prime_d = prime_q;
    last_d  = last_q;
    if (setup) begin
      prev_d  = addr_q;
      prime_d = (state_q != GAP);
      last_d  = (src == 8'd0);
      if (src != 8'd0) begin
        addr_d = lowest_set(src);
        rem_d  = src & ~(8'd1 << lowest_set(src));
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Scan context: captured command, addressing pipeline and data shift register.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      mask_q  <= '0;
      cont_q  <= 1'b0;
      rem_q   <= '0;
      addr_q  <= '0;
      prev_q  <= '0;
      prime_q <= 1'b0;
      last_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      if (start_idle) begin
        mask_q <= mask_in;
        cont_q <= cmd_continuous;
      end else if (state_q != IDLE) begin
        cont_q <= cont_q & cmd_continuous;  // dropping the input cancels the repeat
      end
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
      last_q  <= last_d;
      if ((state_q == FRAME) && sg_rise && (sg_per >= DATA_P)) shift_q <= word[ADC_W-2:0];
    end
  end

  // Result register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      res_valid_q <= 1'b0;
      res_chan_q  <= '0;
      res_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (start_idle) overrun_q <= 1'b0;
      if (load) begin
        res_valid_q <= 1'b1;
        res_chan_q  <= prev_q;
        res_data_q  <= RES_W'(word >> (ADC_W - RES_W));
        if (res_valid_q && !res_ready) overrun_q <= 1'b1;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  // Serial address: MSB first across the address periods, zero elsewhere.
  always_comb begin
    adc_din = 1'b0;
    if (state_q == FRAME) begin
      if (sg_per == ADDR_P)              adc_din = addr_q[2];
      else if (sg_per == ADDR_P + 4'd1)  adc_din = addr_q[1];
      else if (sg_per == ADDR_P + 4'd2)  adc_din = addr_q[0];
    end
  end

  assign adc_cs_n  = (state_q != FRAME);
  assign adc_sclk  = (state_q != FRAME) || sg_hi;
  assign busy      = run;
  assign done      = (state_q == DONE);
  assign res_valid = res_valid_q;
  assign res_chan  = res_chan_q;
  assign res_data  = res_data_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 8; number of ADC input channels, range 2..8.
REQ-002 SHALL have parameter SCLK_DIV, default 25; clk_clk cycles per SCLK half-period, minimum 2.
REQ-003 SHALL have parameter RES_W, default 10; width of the returned result.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk_clk input 1 is the sole clock, and reset_reset_n input 1 is the synchronous active-low reset.
REQ-005 SHALL have cmd_start input 1; single-cycle pulse that starts a scan.
REQ-006 SHALL have cmd_chan_mask input NUM_CH; channels to convert, captured at start.
REQ-007 SHALL have cmd_continuous input 1; when high at scan end, a new scan restarts.
REQ-008 SHALL have adc_cs_n, adc_sclk and adc_din outputs, 1 bit each; serial ADC chip select, clock and address.
REQ-009 SHALL have adc_dout input 1; serial ADC data.
REQ-010 SHALL have res_valid output 1, res_ready input 1, res_chan output 3 and res_data output RES_W; result handshake.
REQ-011 SHALL have busy output 1, done output 1 (single-cycle pulse) and overrun output 1 (sticky).

Function
REQ-012 SHALL run FSM states IDLE, FRAME, GAP, DONE.
REQ-013 SHALL, in IDLE on cmd_start, capture mask and continuous, clear overrun and enter FRAME.
REQ-014 SHALL ignore cmd_start while busy.
REQ-015 SHALL run each FRAME as 16 SCLK periods of 2*SCLK_DIV cycles with adc_cs_n low.
REQ-016 SHALL hold SCLK low for the first half of each period and high for the second half; adc_sclk idles high.
REQ-017 SHALL update adc_din at each period start; SCLK periods 2..4 (0-based) carry the 3-bit address of the next channel, MSB first, and all other periods are 0.
REQ-018 SHALL sample adc_dout on the clk cycle SCLK rises in periods 4..15, forming a 12-bit word MSB first.
REQ-019 SHALL drive res_data as word[11:12-RES_W].
REQ-020 SHALL pipeline addressing: frame k addresses the k-th set mask bit (ascending) and returns the conversion of frame k-1; a scan therefore has popcount(mask)+1 frames.
REQ-021 SHALL discard frame 0 data (priming); the last frame addresses the last channel again.
REQ-022 SHALL, in GAP, hold adc_cs_n high for 2*SCLK_DIV cycles, then enter FRAME or DONE.
REQ-023 SHALL update res_valid, res_chan and res_data one cycle after the final rising edge of a non-priming frame.
REQ-024 SHALL hold res_valid until res_valid and res_ready are both high.
REQ-025 SHALL, when a new result arrives while res_valid is still pending, overwrite the result and set overrun.
REQ-026 SHALL pulse done for one cycle in DONE, then enter FRAME if the captured continuous is high and the mask is non-zero, else IDLE.
REQ-027 SHALL, for mask zero, pulse done on the cycle after start with no frame and busy low.
REQ-028 SHALL drive busy high in FRAME and GAP.

Reset
REQ-029 SHALL, while reset_reset_n is low at a clk_clk edge, set FSM to IDLE, adc_cs_n=1, adc_sclk=1, adc_din=0, res_valid=0, res_chan=0, res_data=0, busy=0, done=0, overrun=0.
REQ-030 SHALL, on reset mid-frame, abort immediately with no partial result and no done pulse.

Structure
REQ-031 SHALL place the FSM state enum, FRAME_BITS=16, ADDR_FIRST=2, DATA_FIRST=4 and ADC_W=12 in package adc_seq_pkg.
REQ-032 SHALL implement a sub-module adc_sclk_gen, a period/half counter that outputs rise/fall strobes and the period index.

Verification
REQ-033 SHALL cover this scenario: SCLK_DIV=2, mask 0x05, ADC model returns 12'h111*(ch+1) -> 3 frames, din addresses 0,2,2, results ch0=0x044 then ch2=0x0CC, one done.
REQ-034 SHALL cover this scenario: mask 0x00 -> done one cycle after start, cs_n stays high, no res_valid.
REQ-035 SHALL cover this scenario: res_ready low throughout, mask 0x03 -> overrun=1, res_chan=1 retained; next cmd_start clears overrun.
REQ-036 SHALL cover this scenario: continuous=1, mask 0x80 -> repeated 2-frame scans with a GAP between; after continuous drops, the current scan completes, then IDLE.
REQ-037 SHALL cover this scenario: reset asserted at frame period 7 -> next cycle cs_n=1, sclk=1, busy=0, no res_valid.
REQ-038 SHALL cover this scenario: cmd_start pulsed while busy -> ignored, and the captured mask is unchanged.
